fifo_wr_arbiter: RTL and testbench

Write-side arbiter that shares the single write port of one async FIFO among `NUM_REQ` requesters in the write clock domain. It grants requesters round-robin and holds each grant for a burst, which ends on the requester's `last` flag or after `MAX_BURST` beats. It forwards the granted requester's data to the FIFO and applies the FIFO's `wfull` back-pressure to that requester only. It sits between the crossbar master ports and the FIFO's `wpush`/`wdata`/`wfull` pins.

---
 rtl/fifo_wr_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one async FIFO write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]  req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          wpush,
    output logic [DATA_SIZE-1:0]          wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [BW-1:0] CAP_CNT  = BW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  rr_ptr, rr_nx, grant_nx, next_ptr, arb_ptr, arb_idx;
    logic [BW-1:0]  beat_cnt, beat_nx;
    logic           arb_found, owner_valid, owner_last, accept, burst_end;
    logic [DATA_SIZE-1:0] owner_data;

    assign busy        = (state == BUSY);
    assign owner_valid = req_valid[grant_id];
    assign owner_last  = req_last[grant_id];
    assign owner_data  = req_data[int'(grant_id)*DATA_SIZE +: DATA_SIZE];
    assign accept      = busy && owner_valid && !wfull;
    assign burst_end   = accept && (owner_last || beat_cnt == CAP_CNT);

    // Wrap explicitly so non-power-of-two requester counts stay in range.
    assign next_ptr = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
    // At a burst end the search starts just past the owner, making it the lowest priority.
    assign arb_ptr  = busy ? next_ptr : rr_ptr;

    always_comb begin : arbiter
        logic [IW-1:0] cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IW'((int'(arb_ptr) + i) % NUM_REQ);
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant_id;
        rr_nx    = rr_ptr;
        beat_nx  = beat_cnt;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    state_nx = BUSY;
                    grant_nx = arb_idx;
                    beat_nx  = '0;
                end
            end
            BUSY: begin
                if (burst_end) begin
                    rr_nx = next_ptr;
                    if (arb_found) begin
                        grant_nx = arb_idx;
                        beat_nx  = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (accept) begin
                    beat_nx = beat_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wpush = accept;
        wdata = busy ? owner_data : '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (grant_id == IW'(i));
        end
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            grant_id <= grant_nx;
            rr_ptr   <= rr_nx;
            beat_cnt <= beat_nx;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          wclk = 1'b0;
    logic          wrst;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          wfull;
    logic          wpush;
    logic [DW-1:0] wdata;
    logic [1:0]    grant_id;
    logic          busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW), .MAX_BURST(MB)) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .wpush(wpush),
        .wdata(wdata), .grant_id(grant_id), .busy(busy)
    );

    always #5 wclk = ~wclk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] l;
        logic       f;
        logic       e_busy;
        logic [1:0] e_gid;
        logic       e_push;
        logic [3:0] e_ready;
    } vec_t;

    vec_t vecs[19];

    task automatic setv(input int k, input logic r, input logic [3:0] v, input logic [3:0] l,
                        input logic f, input logic b, input logic [1:0] g, input logic p,
                        input logic [3:0] rd);
        vecs[k] = '{r, v, l, f, b, g, p, rd};
    endtask

    // Reference model: who owns the port, where the search starts, beats taken so far.
    bit m_busy;
    int m_owner, m_ptr, m_beats;

    function automatic int pick(input int p);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (p + i) % N;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
    endtask

    task automatic model_step();
        int w;
        if (!wrst) begin
            model_reset();
        end else if (!m_busy) begin
            w = pick(m_ptr);
            if (w >= 0) begin m_busy = 1; m_owner = w; m_beats = 0; end
        end else if (req_valid[m_owner] && !wfull) begin
            m_beats++;
            if (req_last[m_owner] || m_beats == MB) begin
                m_ptr = (m_owner + 1) % N;
                w = pick(m_ptr);
                if (w < 0) m_busy = 0;
                else begin m_owner = w; m_beats = 0; end
            end
        end
    endtask

    logic [31:0] q_data [N][$];
    logic        q_last [N][$];
    int          q_start [N];
    logic [31:0] log_data [$];
    int          log_cyc [$];
    logic [N-1:0] cap_ready;
    int cyc, full_mode, full_lo, full_hi;
    bit rand_fill;

    task automatic push_beats(input int r, input logic [31:0] base, input int n, input bit last_end);
        for (int k = 0; k < n; k++) begin
            q_data[r].push_back(base + 32'(k));
            q_last[r].push_back(last_end && (k == n - 1));
        end
    endtask

    task automatic check_outputs();
        logic       acc;
        logic [3:0] er;
        logic [31:0] ed;
        acc = m_busy && req_valid[m_owner] && !wfull;
        er  = acc ? (4'b0001 << m_owner) : 4'b0000;
        ed  = m_busy ? req_data[m_owner*DW +: DW] : 32'h0;
        check("busy", busy, m_busy);
        check("wpush", wpush, acc);
        check("req_ready", req_ready, er);
        check("wdata", wdata, ed);
        if (m_busy) check("grant_id", grant_id, m_owner);
        cap_ready = er;
    endtask

    task automatic do_pops();
        for (int i = 0; i < N; i++) begin
            if (cap_ready[i] && q_data[i].size() != 0) begin
                log_data.push_back(q_data[i][0]);
                log_cyc.push_back(cyc);
                void'(q_data[i].pop_front());
                void'(q_last[i].pop_front());
            end
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (rand_fill && q_data[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                int n;
                n = $urandom_range(1, 6);
                for (int k = 0; k < n; k++) begin
                    q_data[i].push_back($urandom);
                    q_last[i].push_back($urandom_range(0, 2) == 0);
                end
            end
            if (q_data[i].size() != 0 && cyc >= q_start[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*DW +: DW] = q_data[i][0];
                req_last[i] = q_last[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DW +: DW] = $urandom;
                req_last[i] = 1'($urandom_range(0, 1));
            end
        end
        case (full_mode)
            1:       wfull = ($urandom_range(0, 3) == 0);
            2:       wfull = (cyc >= full_lo && cyc <= full_hi);
            default: wfull = 1'b0;
        endcase
    endtask

    task automatic run_cycle();
        @(posedge wclk);
        model_step();
        do_pops();
        #1;
        cyc++;
        wrst = 1'b1;
        drive_inputs();
        @(negedge wclk);
        check_outputs();
    endtask

    // Reset lands mid-cycle with every requester asserting valid.
    task automatic do_reset();
        @(posedge wclk);
        model_step();
        do_pops();
        #1;
        wrst = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            q_data[i].delete();
            q_last[i].delete();
            q_start[i] = 0;
        end
        req_valid = '1;
        req_last  = '0;
        wfull     = 1'b0;
        full_mode = 0;
        cap_ready = '0;
        cyc       = -1;
        @(negedge wclk);
        check("rst busy", busy, 1'b0);
        check("rst wpush", wpush, 1'b0);
        check("rst req_ready", req_ready, 4'h0);
        check("rst wdata", wdata, 32'h0);
    endtask

    task automatic clear_log();
        log_data.delete();
        log_cyc.delete();
    endtask

    initial begin
        wrst = 1'b0; req_valid = '0; req_last = '0; wfull = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hD000_0000 + 32'(i);
        rand_fill = 0; full_mode = 0; full_lo = 0; full_hi = 0; cyc = 0; cap_ready = '0;
        model_reset();

        setv(0,  1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
        setv(1,  1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
        setv(2,  1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 2'd0, 1'b1, 4'h1);
        setv(3,  1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 2'd1, 1'b1, 4'h2);
        setv(4,  1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 2'd2, 1'b1, 4'h4);
        setv(5,  1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 2'd3, 1'b1, 4'h8);
        setv(6,  1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 2'd0, 1'b1, 4'h1);
        setv(7,  1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 1'b0, 4'h0);
        setv(8,  1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 2'd1, 1'b1, 4'h2);
        setv(9,  1'b1, 4'h6, 4'h0, 1'b0, 1'b1, 2'd2, 1'b1, 4'h4);
        setv(10, 1'b1, 4'h6, 4'h0, 1'b0, 1'b1, 2'd2, 1'b1, 4'h4);
        setv(11, 1'b1, 4'h6, 4'h0, 1'b0, 1'b1, 2'd2, 1'b1, 4'h4);
        setv(12, 1'b1, 4'h6, 4'h0, 1'b0, 1'b1, 2'd2, 1'b1, 4'h4);
        setv(13, 1'b1, 4'h6, 4'h0, 1'b0, 1'b1, 2'd1, 1'b1, 4'h2);
        setv(14, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 4'h0);
        setv(15, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 4'h0);
        setv(16, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
        setv(17, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
        setv(18, 1'b1, 4'hF, 4'h0, 1'b0, 1'b1, 2'd0, 1'b1, 4'h1);

        for (int k = 0; k < 19; k++) begin
            logic [31:0] ed;
            @(posedge wclk);
            #1;
            wrst = vecs[k].rst; req_valid = vecs[k].v; req_last = vecs[k].l; wfull = vecs[k].f;
            @(negedge wclk);
            ed = vecs[k].e_busy ? 32'hD000_0000 + 32'(vecs[k].e_gid) : 32'h0;
            check($sformatf("tbl%0d busy", k), busy, vecs[k].e_busy);
            check($sformatf("tbl%0d wpush", k), wpush, vecs[k].e_push);
            check($sformatf("tbl%0d req_ready", k), req_ready, vecs[k].e_ready);
            check($sformatf("tbl%0d wdata", k), wdata, ed);
            if (vecs[k].e_busy) check($sformatf("tbl%0d grant_id", k), grant_id, vecs[k].e_gid);
        end

        // Burst cap: 2 takes 4, then 1 takes 4, then 2 finishes its last 2.
        do_reset(); clear_log();
        push_beats(2, 32'h200, 6, 0);
        push_beats(1, 32'h100, 4, 1);
        q_start[1] = 1;
        for (int k = 0; k < 14; k++) run_cycle();
        check("cap count", log_data.size(), 10);
        begin
            logic [31:0] exp_cap [10];
            exp_cap = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h100,
                        32'h101, 32'h102, 32'h103, 32'h204, 32'h205};
            for (int k = 0; k < 10 && k < log_data.size(); k++)
                check($sformatf("cap beat%0d", k), log_data[k], exp_cap[k]);
        end

        // Sole requester re-granted at the cap with no bubble.
        do_reset(); clear_log();
        push_beats(3, 32'h300, 8, 0);
        for (int k = 0; k < 12; k++) run_cycle();
        check("sole count", log_data.size(), 8);
        for (int k = 0; k < 8 && k < log_data.size(); k++) begin
            check($sformatf("sole data%0d", k), log_data[k], 32'h300 + 32'(k));
            check($sformatf("sole cyc%0d", k), log_cyc[k], k + 1);
        end

        // Back-pressure for 3 cycles in the middle of a 4-beat burst.
        do_reset(); clear_log();
        push_beats(0, 32'hA0, 4, 1);
        full_mode = 2; full_lo = 3; full_hi = 5;
        for (int k = 0; k < 10; k++) run_cycle();
        check("bp count", log_data.size(), 4);
        begin
            int exp_cyc [4];
            exp_cyc = '{1, 2, 6, 7};
            for (int k = 0; k < 4 && k < log_data.size(); k++) begin
                check($sformatf("bp data%0d", k), log_data[k], 32'hA0 + 32'(k));
                check($sformatf("bp cyc%0d", k), log_cyc[k], exp_cyc[k]);
            end
        end

        // Mid-burst reset after 2 beats of requester 0; pointer must restart at 0.
        do_reset(); clear_log();
        push_beats(2, 32'h20, 1, 1);
        push_beats(0, 32'h00, 4, 1);
        q_start[0] = 1;
        for (int k = 0; k < 4; k++) run_cycle();
        do_reset();
        check("midrst count", log_data.size(), 3);
        push_beats(1, 32'h11, 1, 1);
        push_beats(3, 32'h33, 1, 1);
        run_cycle();
        run_cycle();
        check("midrst grant", grant_id, 2'd1);

        // Randomized traffic against the reference model.
        do_reset(); clear_log();
        rand_fill = 1; full_mode = 1;
        for (int k = 0; k < 1500; k++) run_cycle();
        rand_fill = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
